// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants, pending-entry record and grant encoding
package wb_arb_pkg;

  localparam int WB_DATA_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic                 valid;
    logic                 kill;
    logic [4:0]           dest;
    logic [WB_DATA_W-1:0] data;
  } pend_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CORE  = 2'd1,
    DRAIN = 2'd2,
    FORCE = 2'd3
  } grant_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// rtl/wb_pend_fifo.sv - 2-entry pending-result FIFO with per-entry kill-match
module wb_pend_fifo
  import wb_arb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [4:0]           i_push_dest,
  input  logic [WB_DATA_W-1:0] i_push_data,
  input  logic                 i_pop,
  input  logic                 i_kill_en,
  input  logic [4:0]           i_kill_addr,
  output pend_entry_t          o_head,
  output logic [1:0]           o_count
);

  pend_entry_t [1:0] r_ent;
  pend_entry_t [1:0] w_ent_nxt;
  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  pend_entry_t       w_new;

  always_comb begin
    w_ent_nxt   = r_ent;
    w_count_nxt = r_count;
    w_new       = '{valid: 1'b1, kill: 1'b0, dest: i_push_dest, data: i_push_data};

    // Kill is applied to older entries before the push, so a same-cycle push survives.
    for (int i = 0; i < 2; i++) begin
      if (i_kill_en && w_ent_nxt[i].valid && (w_ent_nxt[i].dest == i_kill_addr)) begin
        w_ent_nxt[i].kill = 1'b1;
      end
    end

    if (i_pop && (r_count != 2'd0)) begin
      w_ent_nxt[0] = w_ent_nxt[1];
      w_ent_nxt[1] = '0;
      w_count_nxt  = w_count_nxt - 2'd1;
    end

    if (i_push) begin
      if (w_count_nxt == 2'd0) begin
        w_ent_nxt[0] = w_new;
      end else begin
        w_ent_nxt[1] = w_new;
      end
      w_count_nxt = w_count_nxt + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ent   <= '0;
      r_count <= 2'd0;
    end else begin
      r_ent   <= w_ent_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_head  = r_ent[0];
  assign o_count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter, core vs long-unit results
// Optional same-cycle long-unit bypass when WB_BYPASS_EN is defined.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic              core_jal,
  input  logic [4:0]        core_dest,
  input  logic [DATA_W-1:0] core_data,
  input  logic [DATA_W-1:0] core_link,
  output logic              core_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [4:0]        lu_dest,
  input  logic [DATA_W-1:0] lu_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        pend_count
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  pend_entry_t       w_head;
  logic [1:0]        w_count;
  logic [3:0]        r_starve_cnt;
  grant_e            w_grant;
  logic [4:0]        w_core_dest;
  logic [DATA_W-1:0] w_core_wdata;
  logic              w_core_req;
  logic              w_head_live;
  logic              w_head_dead;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;

  assign w_core_dest  = core_jal ? REG_LINK : core_dest;
  assign w_core_wdata = core_jal ? core_link : core_data;
  assign w_core_req   = core_we && (w_core_dest != REG_ZERO);
  assign w_head_live  = w_head.valid && !w_head.kill;
  assign w_head_dead  = w_head.valid && w_head.kill;

  assign lu_ready   = !rst && (w_count != 2'd2);
  assign pend_count = w_count;

  always_comb begin
    w_grant    = IDLE;
    w_bypass   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = REG_ZERO;
    rf_wdata   = '0;
    core_stall = 1'b0;

    if (!rst) begin
      if ((r_starve_cnt == STARVE_LIM) && w_head_live) w_grant = FORCE;
      else if (w_core_req)                             w_grant = CORE;
      else if (w_head_live)                            w_grant = DRAIN;
`ifdef WB_BYPASS_EN
      else if ((w_count == 2'd0) && lu_valid && (lu_dest != REG_ZERO)) w_bypass = 1'b1;
`endif
    end

    case (w_grant)
      FORCE: begin
        core_stall = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = w_head.dest;
        rf_wdata   = w_head.data;
      end
      CORE: begin
        rf_we    = 1'b1;
        rf_waddr = w_core_dest;
        rf_wdata = w_core_wdata;
      end
      DRAIN: begin
        rf_we    = 1'b1;
        rf_waddr = w_head.dest;
        rf_wdata = w_head.data;
      end
      default: begin
        if (w_bypass) begin
          rf_we    = 1'b1;
          rf_waddr = lu_dest;
          rf_wdata = lu_data;
        end
      end
    endcase
  end

  // A killed head leaves through the same single pop slot as a drained one.
  assign w_pop  = (w_grant == FORCE) || (w_grant == DRAIN) || w_head_dead;
  assign w_push = lu_valid && lu_ready && (lu_dest != REG_ZERO) && !w_bypass;

  wb_pend_fifo u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_push_dest (lu_dest),
    .i_push_data (lu_data),
    .i_pop       (w_pop),
    .i_kill_en   (w_grant == CORE),
    .i_kill_addr (w_core_dest),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if ((w_grant == FORCE) || (w_grant == DRAIN) || (w_count == 2'd0)) begin
      r_starve_cnt <= 4'd0;
    end else if ((w_grant == CORE) && w_head_live && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_we = 1'b0, core_jal = 1'b0;
  logic [4:0]    core_dest = '0;
  logic [DW-1:0] core_data = '0, core_link = '0;
  logic          core_stall;
  logic          lu_valid = 1'b0;
  logic          lu_ready;
  logic [4:0]    lu_dest = '0;
  logic [DW-1:0] lu_data = '0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    pend_count;

  wb_port_arbiter #(.DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_jal(core_jal), .core_dest(core_dest),
    .core_data(core_data), .core_link(core_link), .core_stall(core_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic          stall;
    logic          ready;
    logic [1:0]    cnt;
  } exp_t;

  typedef struct {
    logic [4:0]    dest;
    logic [DW-1:0] data;
    bit            killed;
  } ent_t;

  exp_t exp_q[$];
  ent_t mq[$];
  int   m_starve = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;
  bit   done = 0;

  // Reference: pending results are an ordered list; each cycle picks one writer by priority.
  task automatic model_step(output exp_t e);
    logic [4:0]    cd;
    logic [DW-1:0] cdat;
    bit            creq, live, dead, pop, byp;
    int            n;
    e.we = 0; e.addr = 0; e.data = 0; e.stall = 0; e.ready = 0; e.cnt = 0;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      return;
    end
    cd   = core_jal ? 5'd31 : core_dest;
    cdat = core_jal ? core_link : core_data;
    creq = core_we && (cd != 5'd0);
    n    = mq.size();
    live = (n > 0) && !mq[0].killed;
    dead = (n > 0) && mq[0].killed;
    pop  = 0;
    byp  = 0;
    e.ready = (n < 2);
    e.cnt   = 2'(n);
    if (live && m_starve == SMAX) begin
      e.we = 1; e.addr = mq[0].dest; e.data = mq[0].data; e.stall = 1;
      pop = 1; m_starve = 0;
    end else if (creq) begin
      e.we = 1; e.addr = cd; e.data = cdat;
      if (live && m_starve < SMAX) m_starve++;
      if (dead) pop = 1;
      for (int i = 0; i < n; i++) if (mq[i].dest == cd) mq[i].killed = 1;
    end else if (live) begin
      e.we = 1; e.addr = mq[0].dest; e.data = mq[0].data;
      pop = 1; m_starve = 0;
    end else begin
      if (dead) pop = 1;
`ifdef WB_BYPASS_EN
      if (n == 0 && lu_valid && lu_dest != 5'd0) begin
        e.we = 1; e.addr = lu_dest; e.data = lu_data; byp = 1;
      end
`endif
    end
    if (n == 0) m_starve = 0;
    if (pop) void'(mq.pop_front());
    if (lu_valid && n < 2 && lu_dest != 5'd0 && !byp) begin
      ent_t ne;
      ne.dest = lu_dest; ne.data = lu_data; ne.killed = 0;
      mq.push_back(ne);
    end
  endtask

  task automatic cyc(input bit r, input bit we, input bit jal, input logic [4:0] cdst,
                     input logic [DW-1:0] cdat, input logic [DW-1:0] clink,
                     input bit lv, input logic [4:0] ld, input logic [DW-1:0] ldat);
    exp_t e;
    @(negedge clk);
    rst = r; core_we = we; core_jal = jal; core_dest = cdst; core_data = cdat;
    core_link = clink; lu_valid = lv; lu_dest = ld; lu_data = ldat;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_no, act, req);
    end
  endtask

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 5, 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 32'hA5);
    idle(2);
    cyc(0, 1, 1, 5'd3, 32'h1234, 32'h0040_0010, 0, 0, 0);
    cyc(0, 1, 0, 5'd2, 32'h22, 0, 1, 5'd31, 32'hDEAD);
    cyc(0, 1, 1, 5'd9, 32'h0, 32'h0040_0020, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 5'd3, 32'h33, 0, 1, 5'd7, 32'h77);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 5'd4, 32'h40 + i, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 5'd3, 32'h50, 0, 1, 5'd8, 32'h88);
    cyc(0, 1, 0, 5'd3, 32'h51, 0, 1, 5'd9, 32'h99);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 5'd4, 32'h60 + i, 0, 1, 5'd10, 32'hA0 + i);
    idle(4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hBAD0 + i);
    idle(2);
    cyc(0, 1, 0, 5'd3, 32'h70, 0, 1, 5'd11, 32'hB1);
    cyc(0, 1, 0, 5'd3, 32'h71, 0, 1, 5'd12, 32'hB2);
    cyc(1, 1, 0, 5'd3, 32'h72, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      bit r, we, jal, lv;
      logic [4:0] cdst, ld;
      r    = ($urandom_range(0, 199) == 0);
      we   = ($urandom_range(0, 99) < 65);
      jal  = ($urandom_range(0, 9) == 0);
      cdst = 5'($urandom_range(0, 7));
      lv   = ($urandom_range(0, 99) < 45);
      ld   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      cyc(r, we, jal, cdst, $urandom, $urandom, lv, ld, $urandom);
    end
    idle(4);
    done = 1;
  end

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin
    exp_t e;
    int   wait_cnt;
    wait_cnt = 0;
    while (!(done && exp_q.size() == 0)) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        wait_cnt++;
        if (wait_cnt > 50) begin
          total++;
          bad++;
          $display("FAIL timeout cycle=%0d actual=no_expectation required=expectation", cyc_no);
          break;
        end
        continue;
      end
      wait_cnt = 0;
      e = exp_q.pop_front();
      chk("rf_we", 32'(rf_we), 32'(e.we));
      if (e.we) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("rf_wdata", rf_wdata, e.data);
      end else if (rst) begin
        chk("rf_waddr_rst", 32'(rf_waddr), 32'd0);
        chk("rf_wdata_rst", rf_wdata, 32'd0);
      end
      chk("core_stall", 32'(core_stall), 32'(e.stall));
      chk("lu_ready", 32'(lu_ready), 32'(e.ready));
      chk("pend_count", 32'(pend_count), 32'(e.cnt));
      cyc_no++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_no);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register-file write port between the core writeback path (including JAL link writes to r31) and the long-latency unit (multiply/divide) result path. Core writes take priority. Long-unit results wait in a 2-entry pending buffer, and a starvation counter forces them through by stalling the core. Pending results overwritten by a younger core write are killed, so write-after-write order is preserved.

## Interface
- DATA_W, 32, register data width
- STARVE_MAX, 4, core-granted cycles with a non-empty buffer before a forced drain (1..15)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- core_we  in  1  core requests a writeback this cycle
- core_jal  in  1  link write: destination forced to r31, data = core_link
- core_dest  in  5  core destination (ignored when core_jal=1)
- core_data  in  DATA_W  core result
- core_link  in  DATA_W  PC+4 for JAL
- core_stall  out  1  core must hold its instruction; its write is not performed
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  arbiter can accept a long-unit result
- lu_dest  in  5  long-unit destination
- lu_data  in  DATA_W  long-unit result
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  DATA_W  write data
- pend_count  out  2  valid buffer entries (0..2)

## Operation
- Effective core destination: 31 if core_jal, otherwise core_dest. Effective data: core_link if core_jal, otherwise core_data. A core request is core_we && dest_eff != 0.
- Accept: lu_valid && lu_ready. lu_ready = (pend_count < 2) && !rst.
  - Accepted results with lu_dest = 0 are consumed and dropped, never enqueued.
- Grant priority, evaluated once per cycle:
  - FORCE: starve_cnt == STARVE_MAX and the head entry is live. core_stall=1; the head is written and popped; the core request is ignored.
  - CORE: a core request is present. The core is written; core_stall=0.
  - DRAIN: no core request and the head entry is live. The head is written and popped.
  - IDLE: rf_we=0.
- Kill: when the core write is performed, every valid buffer entry whose dest equals dest_eff gets its kill bit set.
  - A result enqueued in the same cycle is younger and is not killed.
- Killed head: popped in any cycle it sits at the head, with no write. This uses that cycle's single pop. The core may still write in the same cycle.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each CORE cycle while a live head exists.
  - Clears on a FORCE or DRAIN pop, or when the buffer is empty.
- Enqueue and pop in the same cycle are allowed. lu_ready uses the pre-pop count, so a full buffer accepts nothing that cycle.

## Timing
- rf_we, rf_waddr, rf_wdata and core_stall are combinational from the inputs and registered state. The register file writes at the same clk edge.
- The buffer, kill bits and starve_cnt are registered.
- Without bypass, an accepted result is written no earlier than the next cycle.
- A forced drain stalls the core for exactly 1 cycle per entry. The counter clears after the pop, so a second pending entry needs another STARVE_MAX core cycles.
- While rst is high: buffer empty, pend_count=0, starve_cnt=0, core_stall=0, lu_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- Reset asserted mid-operation discards all pending entries immediately.

## Configuration
- WB_BYPASS_EN defined:
  - Applies when the buffer is empty, there is no core request, and FORCE is not active.
  - A valid long-unit result with nonzero lu_dest is written in the same cycle, with lu_ready=1, and is not enqueued.
- WB_BYPASS_EN undefined: every accepted result passes through the buffer, so minimum latency is 1 cycle.

## Structure
- Package wb_arb_pkg holds:
  - REG_ZERO=5'd0 and REG_LINK=5'd31.
  - The pend_entry_t struct {valid, kill, dest[4:0], data[DATA_W-1:0]}.
  - The grant enum {IDLE, CORE, DRAIN, FORCE}.
- Sub-module wb_pend_fifo: 2-entry FIFO with push/pop, per-entry kill-match against a 5-bit address, and head/count outputs.
- Grant logic and starve_cnt live in wb_port_arbiter.

## Test plan
- Reset, then lu_valid with dest 5, data 0xA5, no core request:
  - Without bypass: rf write (5, 0xA5) next cycle.
  - With bypass: same cycle.
- Core JAL with core_link=0x0040_0010: rf write (31, 0x0040_0010) regardless of core_dest.
  - Verify a pending entry with dest 31 gets killed and produces no write.
- Enqueue dest 7, then drive core writes every cycle with STARVE_MAX=4:
  - core_stall=1 on exactly the 5th cycle.
  - The rf write (7, data) happens that cycle.
  - starve_cnt returns to 0.
- Buffer full (two entries) under continuous core writes: lu_ready=0. After one forced pop, lu_ready=1 and pend_count=1.
- lu_dest=0 accepted: pend_count unchanged, no rf write ever.
- Assert rst with two pending entries: pend_count=0 immediately, and no stale write after rst deasserts.
